// File: rtl/cypher_pkg.sv
// Shared types and widths for the cypher entry controller.
// The CYPHER_TIMEOUT_EN build option is handled in cypher_ctrl.
package cypher_pkg;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_CLEAR   = 3'd1,
      ST_COLLECT = 3'd2,
      ST_CHECK   = 3'd3,
      ST_LOCKOUT = 3'd4
   } state_t;

   localparam int DIGIT_CNT_W = 3;
   localparam int TRIES_W     = 4;

   // The timer holds at most N-1, so $clog2(N) bits are enough
   function automatic int timer_width(input int lock_cycles, input int timeout_cycles);
      int longest;
      longest = (lock_cycles > timeout_cycles) ? lock_cycles : timeout_cycles;
      return (longest < 2) ? 1 : $clog2(longest);
   endfunction

   localparam int TIMER_W = timer_width(1000, 5000);

endpackage

// File: rtl/cypher_ctrl_if.sv
// Handshake bundle between the entry controller and its surroundings
// (keypad strobes in, datapath controls and status out).
interface cypher_ctrl_if;
   import cypher_pkg::*;

   logic                   start;
   logic                   digit_valid;
   logic                   stop;
   logic                   sl_res;
   logic                   sl_op;
   logic                   busy;
   logic                   match;
   logic                   fail;
   logic                   lockout;
   logic [DIGIT_CNT_W-1:0] digit_cnt;
   logic [TRIES_W-1:0]     tries;

   modport master (
      output start, digit_valid, stop,
      input  sl_res, sl_op, busy, match, fail, lockout, digit_cnt, tries
   );

   modport slave (
      input  start, digit_valid, stop,
      output sl_res, sl_op, busy, match, fail, lockout, digit_cnt, tries
   );

endinterface

// File: rtl/cypher_timer.sv
// Loadable down-counter that parks at zero; shared by the lockout period
// and the inter-digit timeout.
module cypher_timer
   import cypher_pkg::*;
#(
   parameter int W = TIMER_W
) (
   input  logic         clock,
   input  logic         reset,
   input  logic         load,
   input  logic [W-1:0] value,
   output logic         zero
);

   logic [W-1:0] count_reg;

   always_ff @(posedge clock) begin
      if (reset) begin
         count_reg <= '0;
      end else if (load) begin
         count_reg <= value;
      end else if (count_reg != '0) begin
         count_reg <= count_reg - W'(1);
      end
   end

   assign zero = (count_reg == '0);

endmodule

// File: rtl/cypher_ctrl.sv
// Entry-attempt sequencer in front of the cypher datapath, with failure count and lockout.
// Define CYPHER_TIMEOUT_EN to abort an attempt after TIMEOUT_CYCLES idle cycles between digits.
module cypher_ctrl
   import cypher_pkg::*;
#(
   parameter int DIGITS         = 4,
   parameter int MAX_TRIES      = 3,
   parameter int LOCK_CYCLES    = 1000,
   parameter int TIMEOUT_CYCLES = 5000
) (
   input logic          clock,
   input logic          reset,
   cypher_ctrl_if.slave bus
);

   localparam int TW = timer_width(LOCK_CYCLES, TIMEOUT_CYCLES);
   localparam logic [TW-1:0]          LOCK_LOAD  = TW'(LOCK_CYCLES - 1);
   localparam logic [DIGIT_CNT_W-1:0] LAST_DIGIT = DIGIT_CNT_W'(DIGITS - 1);
   localparam logic [TRIES_W-1:0]     LAST_TRY   = TRIES_W'(MAX_TRIES - 1);

   state_t                 state_reg;
   logic                   match_reg;
   logic                   fail_reg;
   logic [DIGIT_CNT_W-1:0] digit_cnt_reg;
   logic [TRIES_W-1:0]     tries_reg;

   logic                   timer_load;
   logic [TW-1:0]          timer_value;
   logic                   timer_zero;
   logic                   timed_out;
   logic                   attempt_failed;

`ifdef CYPHER_TIMEOUT_EN
   localparam logic [TW-1:0] TIMEOUT_LOAD = TW'(TIMEOUT_CYCLES - 1);
   assign timed_out = (state_reg == ST_COLLECT) && !bus.digit_valid && timer_zero;
`else
   assign timed_out = 1'b0;
`endif

   // stop only matters in CHECK; a cleared register may match a zero cypher earlier
   assign attempt_failed = ((state_reg == ST_CHECK) && !bus.stop) || timed_out;

   always_comb begin
      timer_load  = 1'b0;
      timer_value = LOCK_LOAD;
`ifdef CYPHER_TIMEOUT_EN
      if ((state_reg == ST_CLEAR) || bus.sl_op) begin
         timer_load  = 1'b1;
         timer_value = TIMEOUT_LOAD;
      end
`endif
      if (attempt_failed && (tries_reg == LAST_TRY)) begin
         timer_load  = 1'b1;
         timer_value = LOCK_LOAD;
      end
   end

   cypher_timer #(.W(TW)) u_timer (
      .clock (clock),
      .reset (reset),
      .load  (timer_load),
      .value (timer_value),
      .zero  (timer_zero)
   );

   always_ff @(posedge clock) begin
      if (reset) begin
         state_reg     <= ST_IDLE;
         digit_cnt_reg <= '0;
         tries_reg     <= '0;
         match_reg     <= 1'b0;
         fail_reg      <= 1'b0;
      end else begin
         match_reg <= 1'b0;
         fail_reg  <= 1'b0;
         case (state_reg)
            ST_IDLE: begin
               if (bus.start) state_reg <= ST_CLEAR;
            end
            ST_CLEAR: begin
               digit_cnt_reg <= '0;
               state_reg     <= ST_COLLECT;
            end
            ST_COLLECT: begin
               if (bus.digit_valid) begin
                  digit_cnt_reg <= digit_cnt_reg + DIGIT_CNT_W'(1);
                  if (digit_cnt_reg == LAST_DIGIT) state_reg <= ST_CHECK;
               end
            end
            ST_CHECK: begin
               if (bus.stop) begin
                  match_reg <= 1'b1;
                  tries_reg <= '0;
                  state_reg <= ST_IDLE;
               end
            end
            ST_LOCKOUT: begin
               if (timer_zero) begin
                  tries_reg <= '0;
                  state_reg <= ST_IDLE;
               end
            end
            default: state_reg <= ST_IDLE;
         endcase
         // Mismatch and timeout share the same retry/lockout decision
         if (attempt_failed) begin
            fail_reg  <= 1'b1;
            tries_reg <= tries_reg + TRIES_W'(1);
            state_reg <= (tries_reg == LAST_TRY) ? ST_LOCKOUT : ST_IDLE;
         end
      end
   end

   assign bus.sl_res    = reset || (state_reg == ST_CLEAR);
   assign bus.sl_op     = bus.digit_valid && (state_reg == ST_COLLECT);
   assign bus.busy      = (state_reg == ST_CLEAR) || (state_reg == ST_COLLECT) ||
                          (state_reg == ST_CHECK);
   assign bus.lockout   = (state_reg == ST_LOCKOUT);
   assign bus.match     = match_reg;
   assign bus.fail      = fail_reg;
   assign bus.digit_cnt = digit_cnt_reg;
   assign bus.tries     = tries_reg;

endmodule

// File: tb/tb_cypher_ctrl.sv
// Bench for cypher_ctrl: a nibble shift-register datapath model produces stop,
// scenario tasks compare DUT behaviour against attempt-level expectations.
module tb_cypher_ctrl;
   import cypher_pkg::*;

   localparam int LOCK = 1000;
   localparam int TMO  = 8;
   localparam int MAXT = 3;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic [3:0]  num   = 4'h0;
   logic [15:0] cypher = 16'h1234;
   logic [15:0] dp_sr;

   int n_checks = 0;
   int n_errs   = 0;
   int mon_clear = 0, mon_op = 0, mon_match = 0, mon_fail = 0, mon_lock = 0;

   cypher_ctrl_if cif ();

   cypher_ctrl #(
      .DIGITS(4), .MAX_TRIES(MAXT), .LOCK_CYCLES(LOCK), .TIMEOUT_CYCLES(TMO)
   ) dut (
      .clock (clock),
      .reset (reset),
      .bus   (cif)
   );

   always #5 clock = ~clock;

   function automatic logic [15:0] nib_rev(input logic [15:0] v);
      return {v[3:0], v[7:4], v[11:8], v[15:12]};
   endfunction

   // Datapath stand-in: newest nibble enters at the top, so the reversed value reads in entry order
   always @(posedge clock) begin
      if (cif.sl_res) dp_sr <= 16'h0000;
      else if (cif.sl_op) dp_sr <= {num, dp_sr[15:4]};
   end
   assign cif.stop = (nib_rev(dp_sr) == cypher);

   always begin
      @(negedge clock);
      #2;
      if (!reset && cif.sl_res) mon_clear++;
      if (cif.sl_op)   mon_op++;
      if (cif.match)   mon_match++;
      if (cif.fail)    mon_fail++;
      if (cif.lockout) mon_lock++;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic clear_mon();
      mon_clear = 0; mon_op = 0; mon_match = 0; mon_fail = 0; mon_lock = 0;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      cif.start = 1'b0;
      cif.digit_valid = 1'b0;
      repeat (2) @(negedge clock);
      reset = 1'b0;
      @(negedge clock);
   endtask

   task automatic enter_digit(input logic [3:0] v);
      num = v;
      cif.digit_valid = 1'b1;
      @(negedge clock);
      cif.digit_valid = 1'b0;
   endtask

   task automatic begin_attempt();
      cif.start = 1'b1;
      @(negedge clock);
      cif.start = 1'b0;
      @(negedge clock);
   endtask

   // Full attempt; observes pulses for three cycles after the last digit (c=1 is the cycle after it)
   task automatic run_attempt(input logic [15:0] code, input bit hold_start, input int max_gap,
                              output int match_at, output int fail_at, output int pulses,
                              output int cnt_chk);
      match_at = 0; fail_at = 0; pulses = 0;
      clear_mon();
      cif.start = 1'b1;
      @(negedge clock);
      if (!hold_start) cif.start = 1'b0;
      @(negedge clock);
      for (int i = 0; i < 4; i++) begin
         if (max_gap > 0) repeat ($urandom_range(0, max_gap)) @(negedge clock);
         num = code[15-4*i -: 4];
         cif.digit_valid = 1'b1;
         if (i == 3) cif.start = 1'b0;
         @(negedge clock);
         cif.digit_valid = 1'b0;
      end
      cnt_chk = int'(cif.digit_cnt);
      for (int c = 1; c <= 3; c++) begin
         if (c > 1) @(negedge clock);
         if (cif.match) begin pulses++; if (match_at == 0) match_at = c; end
         if (cif.fail)  begin pulses++; if (fail_at == 0)  fail_at = c;  end
      end
      #3;
      $display("attempt code=%h cypher=%h match_at=%0d fail_at=%0d tries=%0d lockout=%0b",
               code, cypher, match_at, fail_at, cif.tries, cif.lockout);
   endtask

   // Rides out a lockout while hammering start/digit_valid, which must be ignored
   task automatic wait_lockout_end();
      int guard;
      guard = 0;
      while (cif.lockout && guard < 3000) begin
         cif.start = 1'($urandom_range(0, 1));
         cif.digit_valid = 1'($urandom_range(0, 1));
         num = 4'($urandom);
         @(negedge clock);
         guard++;
      end
      cif.start = 1'b0;
      cif.digit_valid = 1'b0;
      #3;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      cif.start = 1'b0;
      cif.digit_valid = 1'b0;
      repeat (2) @(negedge clock);
      n_checks++;
      if (cif.sl_res !== 1'b1) begin n_errs++; $display("FAIL reset_sl_res: got %b want 1", cif.sl_res); end
      n_checks++;
      if ({cif.busy, cif.lockout, cif.match, cif.fail} !== 4'b0000) begin
         n_errs++; $display("FAIL reset_flags: got busy/lock/match/fail=%b want 0000",
                            {cif.busy, cif.lockout, cif.match, cif.fail});
      end
      n_checks++;
      if ({cif.digit_cnt, cif.tries} !== 7'd0) begin
         n_errs++; $display("FAIL reset_counts: got cnt=%0d tries=%0d want 0 0", cif.digit_cnt, cif.tries);
      end
      reset = 1'b0;
      @(negedge clock);
      cif.digit_valid = 1'b1;
      #1;
      n_checks++;
      if ({cif.sl_res, cif.sl_op, cif.busy} !== 3'b000) begin
         n_errs++; $display("FAIL idle_outputs: got sl_res/sl_op/busy=%b want 000", {cif.sl_res, cif.sl_op, cif.busy});
      end
      @(negedge clock);
      cif.digit_valid = 1'b0;
      $display("reset done");
   endtask

   task automatic test_match();
      int m, f, p, cc;
      cypher = 16'h1234;
      run_attempt(16'h1234, 1'b0, 0, m, f, p, cc);
      n_checks++;
      if (m !== 2 || f !== 0 || p !== 1) begin
         n_errs++; $display("FAIL match_latency: got match_at=%0d fail_at=%0d pulses=%0d want 2 0 1", m, f, p);
      end
      n_checks++;
      if (mon_clear !== 1 || mon_op !== 4) begin
         n_errs++; $display("FAIL match_controls: got clears=%0d ops=%0d want 1 4", mon_clear, mon_op);
      end
      n_checks++;
      if (cc !== 4) begin n_errs++; $display("FAIL digit_cnt_check: got %0d want 4", cc); end
      n_checks++;
      if (cif.tries !== 4'd0 || cif.busy !== 1'b0) begin
         n_errs++; $display("FAIL match_after: got tries=%0d busy=%b want 0 0", cif.tries, cif.busy);
      end
   endtask

   task automatic test_lockout();
      int m, f, p, cc;
      cypher = 16'h1234;
      for (int k = 1; k <= MAXT; k++) begin
         run_attempt(16'h1235, 1'b0, 0, m, f, p, cc);
         n_checks++;
         if (f !== 2 || m !== 0 || p !== 1) begin
            n_errs++; $display("FAIL fail_latency_%0d: got fail_at=%0d match_at=%0d pulses=%0d want 2 0 1", k, f, m, p);
         end
         n_checks++;
         if (cif.tries !== 4'(k)) begin n_errs++; $display("FAIL tries_%0d: got %0d want %0d", k, cif.tries, k); end
      end
      n_checks++;
      if (cif.lockout !== 1'b1) begin n_errs++; $display("FAIL lockout_entry: got %b want 1", cif.lockout); end
      mon_op = 0;
      mon_clear = 0;
      wait_lockout_end();
      n_checks++;
      if (mon_lock !== LOCK || cif.lockout !== 1'b0) begin
         n_errs++; $display("FAIL lockout_len: got %0d cycles (lockout=%b) want %0d", mon_lock, cif.lockout, LOCK);
      end
      n_checks++;
      if (mon_op !== 0 || mon_clear !== 0) begin
         n_errs++; $display("FAIL lockout_ignore: got ops=%0d clears=%0d want 0 0", mon_op, mon_clear);
      end
      n_checks++;
      if (cif.tries !== 4'd0 || cif.busy !== 1'b0) begin
         n_errs++; $display("FAIL lockout_exit: got tries=%0d busy=%b want 0 0", cif.tries, cif.busy);
      end
      run_attempt(16'h1234, 1'b0, 0, m, f, p, cc);
      n_checks++;
      if (m !== 2) begin n_errs++; $display("FAIL post_lockout_match: got match_at=%0d want 2", m); end
   endtask

   task automatic test_reset_mid();
      int m, f, p, cc;
      cypher = 16'h1234;
      run_attempt(16'h4321, 1'b0, 0, m, f, p, cc);
      n_checks++;
      if (cif.tries !== 4'd1) begin n_errs++; $display("FAIL pre_abort_tries: got %0d want 1", cif.tries); end
      begin_attempt();
      enter_digit(4'h1);
      enter_digit(4'h2);
      n_checks++;
      if (cif.digit_cnt !== 3'd2) begin n_errs++; $display("FAIL mid_digit_cnt: got %0d want 2", cif.digit_cnt); end
      clear_mon();
      reset = 1'b1;
      #1;
      n_checks++;
      if (cif.sl_res !== 1'b1) begin n_errs++; $display("FAIL abort_sl_res: got %b want 1", cif.sl_res); end
      @(negedge clock);
      reset = 1'b0;
      n_checks++;
      if (cif.busy !== 1'b0 || cif.digit_cnt !== 3'd0 || cif.tries !== 4'd0) begin
         n_errs++; $display("FAIL abort_state: got busy=%b cnt=%0d tries=%0d want 0 0 0",
                            cif.busy, cif.digit_cnt, cif.tries);
      end
      repeat (5) @(negedge clock);
      #3;
      n_checks++;
      if (mon_match !== 0 || mon_fail !== 0 || cif.busy !== 1'b0) begin
         n_errs++; $display("FAIL abort_quiet: got match=%0d fail=%0d busy=%b want 0 0 0", mon_match, mon_fail, cif.busy);
      end
      run_attempt(16'h1234, 1'b0, 0, m, f, p, cc);
      n_checks++;
      if (m !== 2) begin n_errs++; $display("FAIL post_abort_match: got match_at=%0d want 2", m); end
   endtask

   task automatic test_back_to_back();
      int m, f, p, cc;
      cypher = 16'hA5C3;
      run_attempt(16'hA5C3, 1'b1, 0, m, f, p, cc);
      n_checks++;
      if (mon_clear !== 1 || mon_op !== 4 || m !== 2) begin
         n_errs++; $display("FAIL held_start: got clears=%0d ops=%0d match_at=%0d want 1 4 2", mon_clear, mon_op, m);
      end
   endtask

   task automatic test_zero_cypher();
      int m, f, p, cc;
      cypher = 16'h0000;
      run_attempt(16'h1000, 1'b0, 0, m, f, p, cc);
      n_checks++;
      if (f !== 2 || m !== 0 || cif.tries !== 4'd1) begin
         n_errs++; $display("FAIL zero_cypher_fail: got fail_at=%0d match_at=%0d tries=%0d want 2 0 1", f, m, cif.tries);
      end
      run_attempt(16'h0000, 1'b0, 2, m, f, p, cc);
      n_checks++;
      if (m !== 2 || f !== 0 || cif.tries !== 4'd0) begin
         n_errs++; $display("FAIL zero_cypher_match: got match_at=%0d fail_at=%0d tries=%0d want 2 0 0", m, f, cif.tries);
      end
   endtask

   task automatic test_random();
      int m, f, p, cc;
      int exp_tries;
      logic [15:0] code;
      do_reset();
      exp_tries = 0;
      for (int n = 0; n < 10; n++) begin
         cypher = 16'($urandom);
         code = ($urandom_range(0, 2) == 0) ? cypher : 16'($urandom);
         run_attempt(code, 1'($urandom_range(0, 1)), 3, m, f, p, cc);
         n_checks++;
         if (mon_op !== 4 || mon_clear !== 1) begin
            n_errs++; $display("FAIL rnd_controls_%0d: got ops=%0d clears=%0d want 4 1", n, mon_op, mon_clear);
         end
         if (code == cypher) begin
            exp_tries = 0;
            n_checks++;
            if (m !== 2 || f !== 0) begin n_errs++; $display("FAIL rnd_match_%0d: got match_at=%0d fail_at=%0d want 2 0", n, m, f); end
         end else begin
            exp_tries++;
            n_checks++;
            if (f !== 2 || m !== 0) begin n_errs++; $display("FAIL rnd_fail_%0d: got fail_at=%0d match_at=%0d want 2 0", n, f, m); end
         end
         n_checks++;
         if (cif.tries !== 4'(exp_tries)) begin n_errs++; $display("FAIL rnd_tries_%0d: got %0d want %0d", n, cif.tries, exp_tries); end
         if (exp_tries == MAXT) begin
            wait_lockout_end();
            exp_tries = 0;
            n_checks++;
            if (mon_lock !== LOCK || cif.tries !== 4'd0) begin
               n_errs++; $display("FAIL rnd_lockout_%0d: got %0d cycles tries=%0d want %0d 0", n, mon_lock, cif.tries, LOCK);
            end
         end
      end
   endtask

`ifdef CYPHER_TIMEOUT_EN
   task automatic test_timeout();
      int fail_k;
      do_reset();
      cypher = 16'h1234;
      clear_mon();
      begin_attempt();
      enter_digit(4'h1);
      fail_k = 0;
      for (int k = 1; k <= 12; k++) begin
         if (cif.fail && fail_k == 0) fail_k = k;
         @(negedge clock);
      end
      n_checks++;
      if (fail_k !== TMO + 1 || cif.tries !== 4'd1 || cif.busy !== 1'b0) begin
         n_errs++; $display("FAIL timeout_abort: got fail at %0d tries=%0d busy=%b want %0d 1 0",
                            fail_k, cif.tries, cif.busy, TMO + 1);
      end
      $display("timeout attempt fail_at=%0d tries=%0d", fail_k, cif.tries);
      begin_attempt();
      clear_mon();
      num = 4'h1; cif.digit_valid = 1'b1;
      @(negedge clock);
      cif.digit_valid = 1'b0;
      repeat (TMO - 1) @(negedge clock);
      enter_digit(4'h2);
      enter_digit(4'h3);
      enter_digit(4'h4);
      repeat (2) @(negedge clock);
      #3;
      n_checks++;
      if (mon_fail !== 0 || mon_match !== 1 || cif.tries !== 4'd0) begin
         n_errs++; $display("FAIL timeout_reload: got fails=%0d matches=%0d tries=%0d want 0 1 0",
                            mon_fail, mon_match, cif.tries);
      end
      $display("timeout reload attempt matches=%0d fails=%0d", mon_match, mon_fail);
   endtask
`else
   task automatic test_timeout();
      do_reset();
      cypher = 16'h1234;
      clear_mon();
      begin_attempt();
      enter_digit(4'h1);
      repeat (30) @(negedge clock);
      n_checks++;
      if (cif.busy !== 1'b1 || mon_fail !== 0) begin
         n_errs++; $display("FAIL no_timeout: got busy=%b fails=%0d want 1 0", cif.busy, mon_fail);
      end
      enter_digit(4'h2);
      enter_digit(4'h3);
      enter_digit(4'h4);
      repeat (2) @(negedge clock);
      #3;
      n_checks++;
      if (mon_match !== 1) begin n_errs++; $display("FAIL slow_entry_match: got %0d want 1", mon_match); end
      $display("slow attempt matches=%0d fails=%0d", mon_match, mon_fail);
   endtask
`endif

   initial begin
      cif.start = 1'b0;
      cif.digit_valid = 1'b0;
      test_reset();
      test_match();
      test_lockout();
      test_reset_mid();
      test_back_to_back();
      test_zero_cypher();
      test_random();
      test_timeout();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_errs);
      $finish;
   end

endmodule
